mul_issue_ctrl: RTL and testbench

Issue and writeback sequencer for the pipelined DesignWare multiplier stage in the fixed-point unit. It accepts one multiply operation at a time from decode over a valid/ready handshake and drives the multiplier's operand, sign and enable inputs. It counts the pipeline latency, captures the selected result half and condition bits, and holds them for writeback over a second valid/ready handshake. It also maintains a sticky summary-overflow bit. Only one operation is outstanding at a time, matching the pipeline's no-overlap issue policy.

---
 rtl/mul_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback sequencer for a pipelined multiplier: one operation in flight, result held
// for writeback with a sticky summary-overflow bit. Condition fields are laid out {lt, gt, eq, ov}.
module mul_issue_ctrl #(
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_oe,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [3:0]       out_crf,
   output logic             out_ov,
   output logic [TAG_W-1:0] out_tag,
   output logic             so,
   input  logic             so_clr,
   output logic             busy,
   output logic             mul_en,
   output logic             mul_uns,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   input  logic [31:0]      mul_res_hi,
   input  logic [31:0]      mul_res_lo,
   input  logic [3:0]       mul_crf_hi,
   input  logic [3:0]       mul_crf_lo
);
   localparam int unsigned LAT   = STAGES - 1;
   localparam int unsigned CNT_W = (STAGES > 2) ? $clog2(STAGES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        a_q, b_q, res_q;
   logic [1:0]         op_q;
   logic               oe_q, uns_q, ov_q, so_q, so_d;
   logic [TAG_W-1:0]   tag_q, otag_q;
   logic [3:0]         crf_q, sel_crf;
   logic [31:0]        sel_res;
   logic               accept, capture, hi_sel, cap_ov;

   assign accept  = in_valid & in_ready;
   assign capture = (state_q == StBusy) && (cnt_q == '0) && !flush;

   // Ops 01 and 10 return the high word; 00 and 11 the low word.
   assign hi_sel  = op_q[1] ^ op_q[0];
   assign sel_res = hi_sel ? mul_res_hi : mul_res_lo;
   assign sel_crf = hi_sel ? mul_crf_hi : mul_crf_lo;
   assign cap_ov  = ~hi_sel & oe_q & sel_crf[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (accept) state_d = StBusy;
            StBusy:  if (cnt_q == '0) state_d = StDone;
            StDone:  if (out_ready) state_d = accept ? StBusy : StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      mul_en    = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         StIdle: begin
            in_ready = ~flush;
            busy     = 1'b0;
         end
         StBusy: mul_en = 1'b1;
         StDone: begin
            in_ready  = out_ready & ~flush;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      so_d = so_q;
      if (capture) begin
         so_d = (so_q & ~so_clr) | cap_ov;
      end else if (so_clr) begin
         so_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         oe_q   <= 1'b0;
         uns_q  <= 1'b0;
         tag_q  <= '0;
         res_q  <= '0;
         crf_q  <= '0;
         ov_q   <= 1'b0;
         otag_q <= '0;
         so_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            oe_q  <= in_oe;
            uns_q <= (in_op == 2'b10);
            tag_q <= in_tag;
            cnt_q <= CNT_INIT;
         end else if (state_q == StBusy && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (capture) begin
            res_q  <= sel_res;
            crf_q  <= {sel_crf[3:1], so_d};
            ov_q   <= cap_ov;
            otag_q <= tag_q;
         end
         so_q <= so_d;
      end
   end

   assign out_res = res_q;
   assign out_crf = crf_q;
   assign out_ov  = ov_q;
   assign out_tag = otag_q;
   assign so      = so_q;
   assign mul_uns = uns_q;
   assign mul_a   = a_q;
   assign mul_b   = b_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a pipelined multiplier model feeds the DUT, and a scoreboard of
// expected {res, crf, ov, tag} entries is filled on accept and drained on out_valid.
module tb_mul_issue_ctrl;
   localparam int unsigned STAGES = 4;
   localparam int unsigned LAT    = STAGES - 1;
   localparam int unsigned TAG_W  = 5;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_oe = 1'b0;
   logic out_ready = 1'b1, so_clr = 1'b0;
   logic [1:0] in_op = '0;
   logic [31:0] in_a = '0, in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic in_ready, out_valid, out_ov, so, busy, mul_en, mul_uns;
   logic [31:0] out_res, mul_a, mul_b, mul_res_hi, mul_res_lo;
   logic [3:0] out_crf, mul_crf_hi, mul_crf_lo;
   logic [TAG_W-1:0] out_tag;

   int total = 0, bad = 0;
   logic [41:0] sb[$];
   logic m_so = 1'b0;

   always #5 clk = ~clk;

   mul_issue_ctrl #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_oe(in_oe), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_crf(out_crf),
      .out_ov(out_ov), .out_tag(out_tag), .so(so), .so_clr(so_clr), .busy(busy),
      .mul_en(mul_en), .mul_uns(mul_uns), .mul_a(mul_a), .mul_b(mul_b),
      .mul_res_hi(mul_res_hi), .mul_res_lo(mul_res_lo),
      .mul_crf_hi(mul_crf_hi), .mul_crf_lo(mul_crf_lo)
   );

   // Multiplier model: {hi, lo, crf_hi, crf_lo}, advancing only on enabled edges.
   function automatic logic [71:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic uns);
      logic [63:0] p;
      logic [31:0] hi, lo;
      logic ovl;
      if (uns) p = {32'b0, a} * {32'b0, b};
      else p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      hi  = p[63:32];
      lo  = p[31:0];
      ovl = uns ? (hi != 32'd0) : (p[63:31] != {33{p[31]}});
      return {hi, lo, hi[31], ~hi[31] & (|hi), ~(|hi), 1'b0,
              lo[31], ~lo[31] & (|lo), ~(|lo), ovl};
   endfunction

   logic [71:0] pipe [LAT];
   always @(posedge clk) begin
      if (mul_en) begin
         pipe[0] <= mul_model(mul_a, mul_b, mul_uns);
         for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
      end
   end
   assign mul_res_hi = pipe[LAT-1][71:40];
   assign mul_res_lo = pipe[LAT-1][39:8];
   assign mul_crf_hi = pipe[LAT-1][7:4];
   assign mul_crf_lo = pipe[LAT-1][3:0];

   task automatic push_exp(input logic [1:0] op, input logic oe, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
      logic signed [63:0] ps;
      logic [63:0] pu;
      logic [31:0] res;
      logic ov;
      ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      pu = {32'b0, a} * {32'b0, b};
      case (op)
         2'b01:   begin res = ps[63:32]; ov = 1'b0; end
         2'b10:   begin res = pu[63:32]; ov = 1'b0; end
         default: begin res = ps[31:0];  ov = oe && (ps[63:31] != {33{ps[31]}}); end
      endcase
      m_so = m_so | ov;
      sb.push_back({res, res[31], !res[31] && res != 0, res == 0, m_so, ov, tag});
   endtask

   task automatic drive_op(input logic [1:0] op, input logic oe, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
      in_valid = 1'b1; in_op = op; in_oe = oe; in_a = a; in_b = b; in_tag = tag;
   endtask

   // Starts near a negedge; returns at the first negedge after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic oe, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, output bit ok);
      ok = 1'b0;
      drive_op(op, oe, a, b, tag);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         push_exp(op, oe, a, b, tag);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // lat counts negedges since the accepting edge; 1 on entry.
   task automatic wait_out(output bit found, output int lat);
      found = 1'b0;
      lat = 1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin found = 1'b1; break; end
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [41:0] pop_exp();
      if (sb.size() == 0) return 'x;
      return sb.pop_front();
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      total++;
      if ({out_valid, busy, mul_en, so} !== 4'b0)
         begin bad++; $display("FAIL reset_ctl: got %b want 0000", {out_valid, busy, mul_en, so}); end
      total++;
      if ({mul_a, mul_b, mul_uns, out_res, out_tag, out_crf, out_ov} !== '0)
         begin bad++; $display("FAIL reset_data: got %h %h %h want 0", mul_a, mul_b, out_res); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_mullw;
      bit ok, found; int lat; logic [41:0] obs, exp;
      @(negedge clk);
      issue(2'b00, 1'b0, 32'd3, 32'hFFFF_FFFE, 5'h11, ok);
      total++;
      if (!ok || mul_en !== 1'b1 || busy !== 1'b1 || mul_a !== 32'd3 || mul_b !== 32'hFFFF_FFFE)
         begin bad++; $display("FAIL mullw_issue: ok=%0d en=%b a=%h b=%h", ok, mul_en, mul_a, mul_b); end
      wait_out(found, lat);
      total++;
      if (!found || lat != 5) begin bad++; $display("FAIL mullw_lat: got %0d want 5", lat); end
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL mullw_res: got %h want %h", obs, exp); end
      total++;
      if (out_res !== 32'hFFFF_FFFA || out_crf[3] !== 1'b1 || out_tag !== 5'h11)
         begin bad++; $display("FAIL mullw_const: got %h crf %b want fffffffa lt", out_res, out_crf); end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
         begin bad++; $display("FAIL mullw_drain: got valid=%b busy=%b want 0 0", out_valid, busy); end
   endtask

   task automatic test_mulhw;
      bit ok, found; int lat; logic [41:0] obs, exp;
      issue(2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, ok);
      total++;
      if (!ok || mul_uns !== 1'b1) begin bad++; $display("FAIL mulhwu_uns: got %b want 1", mul_uns); end
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!found || obs !== exp) begin bad++; $display("FAIL mulhwu_res: got %h want %h", obs, exp); end
      total++;
      if (out_res !== 32'hFFFF_FFFE || out_crf[3] !== 1'b1)
         begin bad++; $display("FAIL mulhwu_const: got %h want fffffffe", out_res); end
      @(negedge clk);
      issue(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, ok);
      total++;
      if (!ok || mul_uns !== 1'b0) begin bad++; $display("FAIL mulhw_uns: got %b want 0", mul_uns); end
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!found || obs !== exp) begin bad++; $display("FAIL mulhw_res: got %h want %h", obs, exp); end
      total++;
      if (out_res !== 32'h0 || out_crf[1] !== 1'b1)
         begin bad++; $display("FAIL mulhw_const: got %h crf %b want 0 eq", out_res, out_crf); end
      @(negedge clk);
   endtask

   task automatic test_so;
      bit ok, found; int lat; logic [41:0] obs, exp;
      issue(2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 5'h04, ok);
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!ok || !found || obs !== exp) begin bad++; $display("FAIL so_ovf_res: got %h want %h", obs, exp); end
      total++;
      if (so !== 1'b1 || out_ov !== 1'b1 || out_crf !== 4'b0011)
         begin bad++; $display("FAIL so_set: got so=%b ov=%b crf=%b want 1 1 0011", so, out_ov, out_crf); end
      @(negedge clk);
      issue(2'b00, 1'b0, 32'd2, 32'd2, 5'h05, ok);
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!ok || !found || obs !== exp) begin bad++; $display("FAIL so_keep_res: got %h want %h", obs, exp); end
      total++;
      if (so !== 1'b1 || out_ov !== 1'b0)
         begin bad++; $display("FAIL so_sticky: got so=%b ov=%b want 1 0", so, out_ov); end
      @(negedge clk);
      so_clr = 1'b1;
      @(negedge clk);
      so_clr = 1'b0;
      m_so = 1'b0;
      total++;
      if (so !== 1'b0) begin bad++; $display("FAIL so_clr: got %b want 0", so); end
   endtask

   task automatic test_backpressure;
      bit ok, found; int lat, unstable; logic [41:0] held, exp, obs;
      out_ready = 1'b0;
      issue(2'b01, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'h07, ok);
      wait_out(found, lat);
      held = {out_res, out_crf, out_ov, out_tag};
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!out_valid || in_ready || {out_res, out_crf, out_ov, out_tag} !== held) unstable++;
      end
      total++;
      if (!ok || !found || unstable != 0)
         begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
      exp = pop_exp();
      total++;
      if (held !== exp) begin bad++; $display("FAIL bp_res: got %h want %h", held, exp); end
      out_ready = 1'b1;
      drive_op(2'b00, 1'b0, 32'd100, 32'd200, 5'h09);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready: got %b want 1", in_ready); end
      @(posedge clk);
      push_exp(2'b00, 1'b0, 32'd100, 32'd200, 5'h09);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || mul_en !== 1'b1 || out_valid !== 1'b0)
         begin bad++; $display("FAIL bp_chain: got busy=%b en=%b valid=%b want 1 1 0", busy, mul_en, out_valid); end
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!found || lat != 5 || obs !== exp)
         begin bad++; $display("FAIL bp_next: got %h lat %0d want %h lat 5", obs, lat, exp); end
      @(negedge clk);
   endtask

   task automatic test_flush;
      bit ok, found; int lat, seen; logic [41:0] obs, exp; logic so_before;
      so_before = m_so;
      issue(2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 5'h0A, ok);
      @(negedge clk);
      flush = 1'b1;
      drive_op(2'b00, 1'b0, 32'd9, 32'd9, 5'h0B);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      void'(sb.pop_back());
      m_so = so_before;
      total++;
      if (!ok || busy !== 1'b0 || mul_en !== 1'b0 || out_valid !== 1'b0)
         begin bad++; $display("FAIL flush_idle: got busy=%b en=%b valid=%b want 0 0 0", busy, mul_en, out_valid); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      total++;
      if (seen != 0 || so !== so_before)
         begin bad++; $display("FAIL flush_quiet: got %0d active cycles so=%b want 0 so=%b", seen, so, so_before); end
      issue(2'b00, 1'b0, 32'hFFFF_FFF9, 32'd6, 5'h0C, ok);
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!ok || !found || lat != 5 || obs !== exp || out_res !== 32'hFFFF_FFD6)
         begin bad++; $display("FAIL flush_next: got %h lat %0d want %h lat 5", obs, lat, exp); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [1:0] ops[4]; logic oes[4]; logic [31:0] as[4], bs[4];
      int acc_cyc[4]; int issued, got; bit acc; logic [41:0] obs, exp;
      for (int k = 0; k < 4; k++) begin
         ops[k] = 2'($urandom_range(0, 3)); oes[k] = 1'($urandom_range(0, 1));
         as[k] = $urandom; bs[k] = $urandom;
      end
      issued = 0; got = 0;
      for (int c = 0; c < 80 && got < 4; c++) begin
         if (out_valid) begin
            obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL b2b_res%0d: got %h want %h", got, obs, exp); end
            got++;
         end
         if (issued < 4) drive_op(ops[issued], oes[issued], as[issued], bs[issued], 5'(16 + issued));
         else in_valid = 1'b0;
         #1;
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) begin
            push_exp(ops[issued], oes[issued], as[issued], bs[issued], 5'(16 + issued));
            acc_cyc[issued] = c;
            issued++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++;
      if (got != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got); end
      for (int k = 1; k < 4 && k < issued; k++) begin
         total++;
         if (acc_cyc[k] - acc_cyc[k-1] != int'(LAT) + 2)
            begin bad++; $display("FAIL b2b_rate%0d: got %0d want %0d", k, acc_cyc[k] - acc_cyc[k-1], LAT + 2); end
      end
   endtask

   task automatic test_async_reset;
      bit ok, found; int lat; logic [41:0] obs, exp;
      issue(2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 5'h01, ok);
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!ok || !found || obs !== exp) begin bad++; $display("FAIL ar_pre: got %h want %h", obs, exp); end
      @(negedge clk);
      issue(2'b10, 1'b0, 32'd5, 32'd6, 5'h02, ok);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      m_so = 1'b0;
      total++;
      if ({out_valid, busy, mul_en, so} !== 4'b0)
         begin bad++; $display("FAIL ar_clear: got %b want 0000", {out_valid, busy, mul_en, so}); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_ready: got %b want 1", in_ready); end
      @(negedge clk);
      issue(2'b00, 1'b0, 32'd5, 32'd7, 5'h1F, ok);
      wait_out(found, lat);
      obs = {out_res, out_crf, out_ov, out_tag}; exp = pop_exp();
      total++;
      if (!ok || !found || lat != 5 || obs !== exp || out_res !== 32'd35)
         begin bad++; $display("FAIL ar_next: got %h lat %0d want %h lat 5", obs, lat, exp); end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mullw();
      test_mulhw();
      test_so();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
